// File: rtl/spi_burst_memory.sv
`default_nettype none
// ============================================================================
//  Module   : spi_burst_memory
//  Brief    : Pin-level SPI slave memory with burst read/write, address wrap,
//             all four SPI modes and frame-error reporting.
//  Revision : 1.0
// ============================================================================
module spi_burst_memory #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sclk_pin,
    input  logic              cs_pin,
    input  logic              mosi_pin,
    output logic              miso_pin,
    output logic [DATA_W-1:0] last_wdata,
    output logic              busy,
    output logic              frame_err
);

    localparam int   c_DEPTH    = 2 ** ADDR_W;
    localparam int   c_MAX_BITS = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
    localparam int   c_CNT_W    = $clog2(c_MAX_BITS + 1);
    localparam logic c_IDLE_LVL = (CPOL != 0);

    localparam logic [2:0] c_S_IDLE     = 3'd0;
    localparam logic [2:0] c_S_HDR      = 3'd1;
    localparam logic [2:0] c_S_WR       = 3'd2;
    localparam logic [2:0] c_S_RD_FETCH = 3'd3;
    localparam logic [2:0] c_S_RD       = 3'd4;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic r_sclk_prev, r_cs_prev;
    logic r_sclk_rise, r_sclk_fall, r_cs_rise, r_cs_fall, r_mosi_d;

    // CS synchronizer resets low so a frame already in progress at reset release is never seen as a CS fall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_sync <= {SYNC_STAGES{c_IDLE_LVL}};
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_prev <= c_IDLE_LVL;
            r_cs_prev   <= 1'b0;
            r_sclk_rise <= 1'b0;
            r_sclk_fall <= 1'b0;
            r_cs_rise   <= 1'b0;
            r_cs_fall   <= 1'b0;
            r_mosi_d    <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_pin};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_pin};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_pin};
            r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
            r_sclk_rise <= r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
            r_sclk_fall <= ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_prev;
            r_cs_rise   <= r_cs_sync[SYNC_STAGES-1] & ~r_cs_prev;
            r_cs_fall   <= ~r_cs_sync[SYNC_STAGES-1] & r_cs_prev;
            r_mosi_d    <= r_mosi_sync[SYNC_STAGES-1];
        end
    end

    logic w_lead, w_trail, w_sample, w_shift;
    assign w_lead   = (CPOL != 0) ? r_sclk_fall : r_sclk_rise;
    assign w_trail  = (CPOL != 0) ? r_sclk_rise : r_sclk_fall;
    assign w_sample = (CPHA != 0) ? w_trail : w_lead;
    assign w_shift  = (CPHA != 0) ? w_lead : w_trail;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  r_hdr_shift;
    logic [DATA_W-1:0]  r_wr_shift;
    logic [DATA_W-1:0]  r_rd_shift;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_fetch_ph;
    logic               r_wr_pending;
    logic               r_miso_oe;
    logic               r_miso_bit;
    logic [DATA_W-1:0]  r_mem [c_DEPTH];

    logic [ADDR_W:0]   w_hdr_next;
    logic [DATA_W-1:0] w_wr_next;
    assign w_hdr_next = {r_hdr_shift, r_mosi_d};
    assign w_wr_next  = {r_wr_shift[DATA_W-2:0], r_mosi_d};

    always_ff @(posedge clk) begin
        if (r_wr_pending) begin
            r_mem[r_addr] <= r_wr_shift;
        end
        r_rdata <= r_mem[r_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_S_IDLE;
            r_bit_cnt    <= '0;
            r_addr       <= '0;
            r_hdr_shift  <= '0;
            r_wr_shift   <= '0;
            r_rd_shift   <= '0;
            r_fetch_ph   <= 1'b0;
            r_wr_pending <= 1'b0;
            r_miso_oe    <= 1'b0;
            r_miso_bit   <= 1'b0;
            busy         <= 1'b0;
            frame_err    <= 1'b0;
            last_wdata   <= '0;
        end else begin
            frame_err <= 1'b0;
            // The word completed on the previous sample edge commits here, then the burst address advances.
            if (r_wr_pending) begin
                r_wr_pending <= 1'b0;
                last_wdata   <= r_wr_shift;
                r_addr       <= r_addr + ADDR_W'(1);
            end
            if (r_cs_rise && r_state != c_S_IDLE) begin
                r_state   <= c_S_IDLE;
                busy      <= 1'b0;
                r_miso_oe <= 1'b0;
                frame_err <= (r_bit_cnt != '0) && (r_state == c_S_HDR || r_state == c_S_WR);
            end else begin
                case (r_state)
                    c_S_IDLE: begin
                        if (r_cs_fall) begin
                            r_state   <= c_S_HDR;
                            r_bit_cnt <= '0;
                            busy      <= 1'b1;
                            r_miso_oe <= 1'b0;
                        end
                    end
                    c_S_HDR: begin
                        if (w_sample) begin
                            r_hdr_shift <= w_hdr_next[ADDR_W-1:0];
                            if (r_bit_cnt == c_CNT_W'(ADDR_W)) begin
                                r_addr     <= w_hdr_next[ADDR_W:1];
                                r_bit_cnt  <= '0;
                                r_fetch_ph <= 1'b0;
                                r_state    <= w_hdr_next[0] ? c_S_RD_FETCH : c_S_WR;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                            end
                        end
                    end
                    c_S_WR: begin
                        if (w_sample) begin
                            r_wr_shift <= w_wr_next;
                            if (r_bit_cnt == c_CNT_W'(DATA_W - 1)) begin
                                r_bit_cnt    <= '0;
                                r_wr_pending <= 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                            end
                        end
                    end
                    c_S_RD_FETCH: begin
                        // Phase 0 lets the registered read settle; phase 1 loads the shifter.
                        if (!r_fetch_ph) begin
                            r_fetch_ph <= 1'b1;
                        end else begin
                            r_fetch_ph <= 1'b0;
                            r_rd_shift <= r_rdata;
                            r_bit_cnt  <= '0;
                            r_state    <= c_S_RD;
                        end
                    end
                    c_S_RD: begin
                        if (w_shift) begin
                            r_miso_oe  <= 1'b1;
                            r_miso_bit <= r_rd_shift[DATA_W-1];
                            r_rd_shift <= {r_rd_shift[DATA_W-2:0], 1'b0};
                        end
                        if (w_sample) begin
                            if (r_bit_cnt == c_CNT_W'(DATA_W - 1)) begin
                                r_bit_cnt  <= '0;
                                r_addr     <= r_addr + ADDR_W'(1);
                                r_fetch_ph <= 1'b0;
                                r_state    <= c_S_RD_FETCH;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        r_state <= c_S_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Release the pin as soon as the CS rise is detected, one clk ahead of the FSM.
    assign miso_pin = (r_miso_oe && !r_cs_rise) ? r_miso_bit : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_spi_burst_memory.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_burst_memory
//  Brief    : Directed self-checking bench for spi_burst_memory, mode 0 and mode 3.
//  Revision : 1.0
// ============================================================================
module tb_spi_burst_memory;

    localparam int c_HALF = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        sclk0, cs0, mosi0;
    wire         miso0;
    logic [7:0]  lw0;
    logic        busy0, fe0;
    logic        sclk1, cs1, mosi1;
    wire         miso1;
    logic [15:0] lw1;
    logic        busy1, fe1;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_cnt0  = 0;
    int fe_cnt1  = 0;
    logic [31:0] rx;

    spi_burst_memory u_dut0 (
        .clk(clk), .reset_n(reset_n), .sclk_pin(sclk0), .cs_pin(cs0), .mosi_pin(mosi0),
        .miso_pin(miso0), .last_wdata(lw0), .busy(busy0), .frame_err(fe0)
    );

    spi_burst_memory #(.ADDR_W(4), .DATA_W(16), .CPOL(1), .CPHA(1), .SYNC_STAGES(2)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .sclk_pin(sclk1), .cs_pin(cs1), .mosi_pin(mosi1),
        .miso_pin(miso1), .last_wdata(lw1), .busy(busy1), .frame_err(fe1)
    );

    always @(negedge clk) begin
        if (fe0) fe_cnt0 = fe_cnt0 + 1;
        if (fe1) fe_cnt1 = fe_cnt1 + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Mode 0: data set while SCLK low, sampled on rise.
    task automatic xfer0(input int nbits, input logic [31:0] tx, output logic [31:0] r);
        r = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi0 = tx[i];
            tick(c_HALF);
            r = {r[30:0], miso0};
            sclk0 = 1'b1;
            tick(c_HALF);
            sclk0 = 1'b0;
        end
    endtask

    // Mode 3: data changes on the falling leading edge, sampled on rise.
    task automatic xfer1(input int nbits, input logic [31:0] tx, output logic [31:0] r);
        r = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            sclk1 = 1'b0;
            mosi1 = tx[i];
            tick(c_HALF);
            r = {r[30:0], miso1};
            sclk1 = 1'b1;
            tick(c_HALF);
        end
    endtask

    task automatic cs_lo0(); cs0 = 1'b0; tick(c_HALF); endtask
    task automatic cs_hi0(); tick(c_HALF); cs0 = 1'b1; tick(10); endtask
    task automatic cs_lo1(); cs1 = 1'b0; tick(c_HALF); endtask
    task automatic cs_hi1(); tick(c_HALF); cs1 = 1'b1; tick(10); endtask

    task automatic frame0(input logic [7:0] hdr, input int nbits, input logic [31:0] tx,
                          output logic [31:0] r);
        logic [31:0] dummy;
        cs_lo0();
        xfer0(8, {24'd0, hdr}, dummy);
        xfer0(nbits, tx, r);
        cs_hi0();
    endtask

    initial begin
        reset_n = 1'b0;
        sclk0 = 1'b0; cs0 = 1'b1; mosi0 = 1'b0;
        sclk1 = 1'b1; cs1 = 1'b1; mosi1 = 1'b0;
        tick(4);
        check("rst_busy0", 32'(busy0), 32'd0);
        check("rst_fe0", 32'(fe0), 32'd0);
        check("rst_lw0", 32'(lw0), 32'd0);
        check("rst_miso0_z", 32'(miso0 === 1'bz), 32'd1);
        check("rst_busy1", 32'(busy1), 32'd0);
        check("rst_lw1", 32'(lw1), 32'd0);
        reset_n = 1'b1;
        tick(4);

        // Single write: mem[1] = 0x55
        cs_lo0();
        check("busy0_in_frame", 32'(busy0), 32'd1);
        xfer0(8, 32'h02, rx);
        xfer0(8, 32'h55, rx);
        cs_hi0();
        check("wr1_lw0", 32'(lw0), 32'h55);
        check("wr1_busy0_idle", 32'(busy0), 32'd0);
        check("wr1_no_fe", 32'(fe_cnt0), 32'd0);

        // Single read of mem[1]
        cs_lo0();
        xfer0(8, 32'h03, rx);
        check("rd1_miso_z_before", 32'(miso0 === 1'bz), 32'd1);
        xfer0(8, 32'h00, rx);
        check("rd1_data", rx, 32'h55);
        cs_hi0();
        check("rd1_miso_z_after", 32'(miso0 === 1'bz), 32'd1);

        // Burst write/read across the 0x7F -> 0x00 wrap
        frame0(8'hFE, 24, 32'hA1B2C3, rx);
        check("bw_lw0", 32'(lw0), 32'hC3);
        frame0(8'hFF, 24, 32'h0, rx);
        check("br_data", rx, 32'hA1B2C3);
        frame0(8'h03, 8, 32'h0, rx);
        check("br_mem1", rx, 32'hC3);

        // Partial word discarded; frame_err once
        frame0(8'h04, 8, 32'h3C, rx);
        frame0(8'h04, 4, 32'hF, rx);
        check("pw_fe_once", 32'(fe_cnt0), 32'd1);
        check("pw_lw0_kept", 32'(lw0), 32'h3C);
        frame0(8'h05, 8, 32'h0, rx);
        check("pw_mem2_kept", rx, 32'h3C);
        frame0(8'h04, 8, 32'h0F, rx);
        check("clean_no_fe", 32'(fe_cnt0), 32'd1);
        frame0(8'h05, 8, 32'h0, rx);
        check("clean_mem2", rx, 32'h0F);

        // Partial header
        cs_lo0();
        xfer0(3, 32'h5, rx);
        cs_hi0();
        check("ph_fe", 32'(fe_cnt0), 32'd2);

        // Reset mid-word of a write
        frame0(8'h06, 8, 32'h77, rx);
        cs_lo0();
        xfer0(8, 32'h06, rx);
        xfer0(4, 32'h9, rx);
        reset_n = 1'b0;
        tick(3);
        check("mr_busy0", 32'(busy0), 32'd0);
        check("mr_fe0", 32'(fe0), 32'd0);
        check("mr_lw0", 32'(lw0), 32'd0);
        check("mr_miso0_z", 32'(miso0 === 1'bz), 32'd1);
        reset_n = 1'b1;
        tick(2);
        cs0 = 1'b1;
        tick(10);
        check("mr_no_fe", 32'(fe_cnt0), 32'd2);
        frame0(8'h07, 8, 32'h0, rx);
        check("mr_mem3_kept", rx, 32'h77);
        frame0(8'h06, 8, 32'h99, rx);
        check("mr_next_lw0", 32'(lw0), 32'h99);
        frame0(8'h07, 8, 32'h0, rx);
        check("mr_next_mem3", rx, 32'h99);

        // Mode 3, 4-bit address, 16-bit data, wrap 0xF -> 0x0
        cs_lo1();
        check("m3_busy1", 32'(busy1), 32'd1);
        xfer1(5, 32'h1E, rx);
        xfer1(32, 32'hBEEF1234, rx);
        cs_hi1();
        check("m3_lw1", 32'(lw1), 32'h1234);
        check("m3_no_fe", 32'(fe_cnt1), 32'd0);
        cs_lo1();
        xfer1(5, 32'h1F, rx);
        xfer1(32, 32'h0, rx);
        check("m3_rd", rx, 32'hBEEF1234);
        cs_hi1();
        check("m3_miso1_z", 32'(miso1 === 1'bz), 32'd1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
